// File: rtl/debug_pkg.sv
// Shared debug-path definitions: loader FSM states, word widths and an address range helper.
package debug_pkg;

    localparam int RISCV_INSTR_W = 32;
    localparam int DBG_ADDR_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } dbg_load_state_t;

    // True when the word address fits an IMEM of 2**aw words.
    function automatic logic addr_in_range(input logic [DBG_ADDR_W-1:0] addr, input int aw);
        return (addr >> aw) == '0;
    endfunction

endpackage

// File: rtl/debug_imem_loader_if.sv
// Debug program-load stream: one word per cycle from the debug source to the IMEM loader.
interface debug_imem_loader_if;
    import debug_pkg::*;

    logic                     DEBUG_SIG;
    logic [DBG_ADDR_W-1:0]    DEBUG_addr;
    logic [RISCV_INSTR_W-1:0] DEBUG_instr;
    logic                     START;

    modport master (
        output DEBUG_SIG,
        output DEBUG_addr,
        output DEBUG_instr,
        output START
    );

    modport slave (
        input DEBUG_SIG,
        input DEBUG_addr,
        input DEBUG_instr,
        input START
    );

endinterface

// File: rtl/debug_imem_wr_stage.sv
// One-cycle registered IMEM write port; with DEBUG_LOADER_CSUM_EN it also sums every issued write.
module debug_imem_wr_stage
    import debug_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [RISCV_INSTR_W-1:0] wr_data,
`ifdef DEBUG_LOADER_CSUM_EN
    input  logic                     csum_clr,
`endif
    output logic                     we,
    output logic [AW-1:0]            addr,
    output logic [RISCV_INSTR_W-1:0] data,
    output logic [31:0]              csum
);

    // Address and data hold between writes so the port only toggles on real strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            we   <= 1'b0;
            addr <= '0;
            data <= '0;
        end else begin
            we <= wr_en;
            if (wr_en) begin
                addr <= wr_addr;
                data <= wr_data;
            end
        end
    end

`ifdef DEBUG_LOADER_CSUM_EN
    logic [31:0] csum_q;
    logic [31:0] csum_base;
    logic [31:0] csum_add;

    // A reload restarts the sum with its first word, so clear and add can share one edge.
    always_comb begin
        csum_base = csum_clr ? 32'd0 : csum_q;
        csum_add  = wr_en ? wr_data : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (csum_clr || wr_en) begin
            csum_q <= csum_base + csum_add;
        end
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

endmodule

// File: rtl/debug_imem_loader.sv
// Debug program loader: writes the load stream into IMEM and holds the core in reset until START.
// Optional feature macro: DEBUG_LOADER_CSUM_EN (running checksum of written words on load_csum).
module debug_imem_loader
    import debug_pkg::*;
#(
    parameter int AW    = 10,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    debug_imem_loader_if.slave       dbg,
    output logic                     imem_we,
    output logic [AW-1:0]            imem_waddr,
    output logic [RISCV_INSTR_W-1:0] imem_wdata,
    output logic                     core_rst,
    output logic                     load_done,
    output logic                     load_err,
    output logic [CNT_W-1:0]         word_count,
    output logic [31:0]              load_csum
);

    dbg_load_state_t state;
    dbg_load_state_t next_state;
    logic            prev_sig;
    logic            accept;
    logic            reload;
    logic            in_range;
    logic            wr_en;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        reload     = 1'b0;
        in_range   = addr_in_range(dbg.DEBUG_addr, AW);
        case (state)
            IDLE: begin
                if (dbg.DEBUG_SIG && !dbg.START) begin
                    accept     = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (dbg.START) begin
                    next_state = RUN;
                end else if (dbg.DEBUG_SIG) begin
                    accept = 1'b1;
                end
            end
            RUN: begin
                // Only a fresh rising DEBUG_SIG restarts a load; a held level is stale.
                if (dbg.DEBUG_SIG && !dbg.START && !prev_sig) begin
                    accept     = 1'b1;
                    reload     = 1'b1;
                    next_state = LOAD;
                end
            end
            default: next_state = IDLE;
        endcase
        wr_en = accept && in_range;
    end

    // Release waits one edge in RUN so the final write lands while the core is still in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev_sig   <= 1'b0;
            core_rst   <= 1'b1;
            load_done  <= 1'b0;
            word_count <= '0;
            load_err   <= 1'b0;
        end else begin
            state     <= next_state;
            prev_sig  <= dbg.DEBUG_SIG;
            core_rst  <= !(state == RUN && next_state == RUN);
            load_done <= (state == RUN && next_state == RUN);
            if (reload) begin
                word_count <= CNT_W'(wr_en);
                load_err   <= accept && !in_range;
            end else begin
                if (wr_en && word_count != '1) begin
                    word_count <= word_count + CNT_W'(1);
                end
                if (accept && !in_range) begin
                    load_err <= 1'b1;
                end
            end
        end
    end

    debug_imem_wr_stage #(
        .AW(AW)
    ) u_wr_stage (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (dbg.DEBUG_addr[AW-1:0]),
        .wr_data  (dbg.DEBUG_instr),
`ifdef DEBUG_LOADER_CSUM_EN
        .csum_clr (reload),
`endif
        .we       (imem_we),
        .addr     (imem_waddr),
        .data     (imem_wdata),
        .csum     (load_csum)
    );

endmodule

// File: tb/tb_debug_imem_loader.sv
// Self-checking bench for debug_imem_loader: directed load/release/reload/reset steps, then random traffic.
module tb_debug_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_we;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        load_done;
    logic        load_err;
    logic [15:0] word_count;
    logic [31:0] load_csum;

    debug_imem_loader_if dbg_if ();

    debug_imem_loader #(
        .AW    (10),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dbg        (dbg_if),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count),
        .load_csum  (load_csum)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 waiting, 1 loading, 2 released; run_age counts edges spent released.
    int          m_phase;
    int          m_age;
    bit          m_prev;
    logic [15:0] m_count;
    bit          m_err;
    logic [31:0] m_csum;
    bit          e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_data;
    bit          e_core_rst;
    bit          e_done;
    bit          chk_bus;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input bit r, input bit s, input logic [31:0] a,
                             input logic [31:0] d, input bit st);
        bit acc;
        bit fresh;
        if (r) begin
            m_phase = 0; m_age = 0; m_prev = 0;
            m_count = 0; m_err = 0; m_csum = 0;
            e_we = 0; e_addr = 0; e_data = 0;
            e_core_rst = 1; e_done = 0; chk_bus = 1;
            return;
        end
        chk_bus = 0;
        e_we    = 0;
        acc     = 0;
        fresh   = 0;
        case (m_phase)
            0: if (s && !st) begin acc = 1; m_phase = 1; end
            1: if (st) begin m_phase = 2; m_age = 0; end else if (s) acc = 1;
            default: begin
                m_age++;
                if (s && !st && !m_prev) begin acc = 1; fresh = 1; m_phase = 1; end
            end
        endcase
        if (fresh) begin
            m_count = 0; m_err = 0; m_csum = 0;
        end
        if (acc) begin
            if (a < 32'd1024) begin
                e_we   = 1;
                e_addr = a[9:0];
                e_data = d;
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
`ifdef DEBUG_LOADER_CSUM_EN
                m_csum = m_csum + d;
`endif
            end else begin
                m_err = 1;
            end
        end
        e_core_rst = !(m_phase == 2 && m_age >= 1);
        e_done     = !e_core_rst;
        m_prev     = s;
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".we"}, {31'd0, imem_we}, {31'd0, e_we});
        if (e_we || chk_bus) begin
            chk({tag, ".waddr"}, {22'd0, imem_waddr}, {22'd0, e_addr});
            chk({tag, ".wdata"}, imem_wdata, e_data);
        end
        chk({tag, ".core_rst"}, {31'd0, core_rst}, {31'd0, e_core_rst});
        chk({tag, ".load_done"}, {31'd0, load_done}, {31'd0, e_done});
        chk({tag, ".load_err"}, {31'd0, load_err}, {31'd0, m_err});
        chk({tag, ".word_count"}, {16'd0, word_count}, {16'd0, m_count});
        chk({tag, ".load_csum"}, load_csum, m_csum);
    endtask

    task automatic applyStimulus(input string tag, input bit r, input bit s,
                                 input logic [31:0] a, input logic [31:0] d, input bit st);
        @(negedge clk);
        rst                = r;
        dbg_if.DEBUG_SIG   = s;
        dbg_if.DEBUG_addr  = a;
        dbg_if.DEBUG_instr = d;
        dbg_if.START       = st;
        modelStep(r, s, a, d, st);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [31:0] ra;
        bit          rr;
        bit          rs;
        bit          rst_q;
        rst                = 1'b1;
        dbg_if.DEBUG_SIG   = 1'b0;
        dbg_if.DEBUG_addr  = '0;
        dbg_if.DEBUG_instr = '0;
        dbg_if.START       = 1'b0;
        $display("[TB] start");

        // Reset, including a valid word presented while reset is held.
        applyStimulus("reset0", 1, 0, 0, 0, 0);
        applyStimulus("reset1", 1, 1, 3, 32'h1111_2222, 0);

        // Contiguous load of 15 words, then START and release.
        for (int i = 0; i < 15; i++)
            applyStimulus("load", 0, 1, i, 32'h1000_0000 + 32'(i) * 32'd7, 0);
        applyStimulus("start", 0, 0, 0, 0, 1);
        chk("count15", {16'd0, word_count}, 32'd15);
        chk("held_after_start", {31'd0, core_rst}, 32'd1);
        applyStimulus("run1", 0, 0, 0, 0, 0);
        chk("released", {31'd0, core_rst}, 32'd0);
        applyStimulus("run2", 0, 0, 0, 0, 0);

        // Reload from RUN on a rising DEBUG_SIG.
        applyStimulus("reload", 0, 1, 5, 32'h00A0_0093, 0);
        chk("reload_rst", {31'd0, core_rst}, 32'd1);
        chk("reload_we", {31'd0, imem_we}, 32'd1);
        chk("reload_addr", {22'd0, imem_waddr}, 32'd5);
        chk("reload_data", imem_wdata, 32'h00A0_0093);
        chk("reload_count", {16'd0, word_count}, 32'd1);

        // Address range boundaries, non-contiguous and duplicate addresses.
        applyStimulus("top_ok", 0, 1, 32'h0000_03FF, 32'hCAFE_0001, 0);
        applyStimulus("first_bad", 0, 1, 32'h0000_0400, 32'hCAFE_0002, 0);
        applyStimulus("all_ones", 0, 1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0);
        chk("err_set", {31'd0, load_err}, 32'd1);
        chk("err_no_we", {31'd0, imem_we}, 32'd0);
        applyStimulus("dup", 0, 1, 5, 32'h0000_0013, 0);

        // DEBUG_SIG and START together: word ignored, go to RUN, error stays.
        applyStimulus("sig_start", 0, 1, 7, 32'h1234_5678, 1);
        chk("sig_start_we", {31'd0, imem_we}, 32'd0);
        applyStimulus("rel2", 0, 0, 0, 0, 0);
        chk("err_sticky", {31'd0, load_err}, 32'd1);
        chk("done2", {31'd0, load_done}, 32'd1);
        applyStimulus("level_held", 0, 1, 8, 32'h0, 1);
        applyStimulus("level_held2", 0, 1, 8, 32'h0, 0);

        // Reset aborting a load, both concurrent with a word and one cycle after.
        applyStimulus("drop", 0, 0, 0, 0, 0);
        applyStimulus("reload2", 0, 1, 9, 32'h0000_0999, 0);
        applyStimulus("rst_with_word", 1, 1, 10, 32'h0000_0AAA, 0);
        chk("rst_with_word_we", {31'd0, imem_we}, 32'd0);
        applyStimulus("word", 0, 1, 11, 32'h0000_0BBB, 0);
        applyStimulus("rst_after", 1, 0, 0, 0, 0);
        chk("rst_after_we", {31'd0, imem_we}, 32'd0);
        chk("rst_after_count", {16'd0, word_count}, 32'd0);

        // Checksum wraps modulo 2^32.
        applyStimulus("csum_a", 0, 1, 1, 32'hFFFF_FFFF, 0);
        applyStimulus("csum_b", 0, 1, 2, 32'h0000_0002, 0);
`ifdef DEBUG_LOADER_CSUM_EN
        chk("csum_wrap", load_csum, 32'h0000_0001);
`else
        chk("csum_tied", load_csum, 32'h0000_0000);
`endif
        applyStimulus("csum_start", 0, 0, 0, 0, 1);

        // Random traffic against the model.
        rst_q = 0;
        for (int n = 0; n < 400; n++) begin
            rr = ($urandom_range(0, 99) == 0) && !rst_q;
            rst_q = rr;
            rs = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       ra = $urandom;
                1:       ra = 32'h0000_0400;
                2:       ra = 32'h0000_03FF;
                default: ra = 32'($urandom_range(0, 1023));
            endcase
            applyStimulus("rand", rr, rs, ra, $urandom, ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_imem_loader.md
# debug_imem_loader

Receiving end of the debug program-load stream. Accepts the per-cycle `DEBUG_SIG` / `DEBUG_addr` / `DEBUG_instr` / `START` stream from the debug source and writes each valid word into the core's instruction memory through a registered write port. It holds the core in reset while loading and releases it once `START` is seen. It sits between the debug source and the IMEM write port / core reset at the top level.

## Interface
Parameters:
- `AW`, 10: IMEM word-address width; depth = 2**AW words.
- `CNT_W`, 16: width of the accepted-word counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `DEBUG_SIG`  in  1  load-stream valid.
- `DEBUG_addr`  in  32  word address of `DEBUG_instr`.
- `DEBUG_instr`  in  32  instruction word.
- `START`  in  1  end of load; run request.
- `imem_we`  out  1  IMEM write strobe.
- `imem_waddr`  out  AW  IMEM word address.
- `imem_wdata`  out  32  IMEM write data.
- `core_rst`  out  1  holds the core in reset, active-high.
- `load_done`  out  1  level; a load completed and the core is running.
- `load_err`  out  1  sticky; a word was dropped for an out-of-range address.
- `word_count`  out  CNT_W  words written in the current load, saturating.
- `load_csum`  out  32  checksum of written words (see Configuration).

## Operation
- FSM states: `IDLE`, `LOAD`, `RUN`.
- **IDLE**
  - `core_rst`=1.
  - Goes to `LOAD` when `DEBUG_SIG`=1 and `START`=0.
  - The word on that same cycle is accepted.
- **LOAD**
  - `core_rst`=1.
  - A word is accepted when `DEBUG_SIG`=1 and `START`=0.
  - Accepted word with `DEBUG_addr` < 2**AW: issue one IMEM write with `imem_waddr`=`DEBUG_addr[AW-1:0]`; `word_count` +1, saturating at all-ones.
  - Accepted word with `DEBUG_addr` ≥ 2**AW (this includes 0xFFFFFFFF): drop it and set `load_err`.
  - `START`=1 goes to `RUN`, regardless of `DEBUG_SIG`. A word present on that cycle is ignored.
- **RUN**
  - `core_rst`=0, `load_done`=1.
  - A `DEBUG_SIG` level is ignored while `START`=1.
  - A `DEBUG_SIG` 0→1 edge with `START`=0 starts a reload: go to `LOAD` and accept that word. On entry, `core_rst`=1, `load_done`=0, `word_count`, `load_err` and `load_csum` all clear, and the accepted word counts as the first of the new load.
- Previous `DEBUG_SIG` is registered for edge detection. Reset value 0.
- Duplicate addresses are legal; the last write wins.
- Non-contiguous addresses are legal.

## Timing
- Reset values:
  - state=`IDLE`, `core_rst`=1.
  - `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0.
  - `load_done`=0, `load_err`=0, `word_count`=0, `load_csum`=0.
- All outputs are registered.
- Write latency: an accepted word on cycle N gives `imem_we`=1 with its address and data on cycle N+1, for exactly one cycle.
- Throughput: one word per cycle, no back-pressure.
- Release: `START` sampled at edge N gives `core_rst`=0 and `load_done`=1 after edge N+1. The last write (cycle N) completes before the core leaves reset.
- `word_count`, `load_err` and `load_csum` update in the same cycle as the corresponding `imem_we`.
- `rst` mid-load aborts immediately: the pending write is not issued, and the block returns to `IDLE` with the core held in reset.

## Configuration
- `DEBUG_LOADER_CSUM_EN`
  - Defined: `load_csum` is a 32-bit modulo-2^32 sum of the `imem_wdata` of every issued write in the current load. It clears on reset and on reload entry.
  - Undefined: no adder or register; `load_csum` is tied to 0.

## Structure
- Shared package `debug_pkg`:
  - state enum `dbg_load_state_t` (`IDLE`, `LOAD`, `RUN`);
  - `RISCV_INSTR_W`=32;
  - `DBG_ADDR_W`=32.
- Sub-module `debug_imem_wr_stage`: the one-cycle registered write stage (`we`/`addr`/`data`, plus the checksum accumulator under the macro).
- FSM, counter and error logic live in the top module.

## Test plan
- Reset, then `DEBUG_addr`=0..14 on consecutive cycles with `DEBUG_SIG`=1, then `START`=1 → 15 writes at addresses 0..14, one cycle after each input; `word_count`=15; `core_rst` falls 2 cycles after `START`.
- During a load, `DEBUG_addr`=0xFFFFFFFF with `DEBUG_SIG`=1 → no write; `load_err`=1 and stays set through `START`.
- In `LOAD`, `DEBUG_SIG`=1 and `START`=1 on the same cycle → no write; go to `RUN`.
- In `RUN`, `DEBUG_SIG` 0→1 with `START`=0 and `DEBUG_addr`=5, `DEBUG_instr`=0x00A00093 → `core_rst`=1; one write to address 5 with that data; `word_count`=1.
- Assert `rst` on the cycle after an accepted word → no `imem_we`; all outputs at reset values.
- With `DEBUG_LOADER_CSUM_EN` defined, write 0xFFFFFFFF then 0x00000002 → `load_csum`=0x00000001.
